// File: rtl/uart_sha_host.sv
// Host-side initiator for the UART SHA-256 mining protocol: serialises a job
// as 'H' + 136 shadow bytes, checks the '1'/'S'/'Y' replies and returns the nonce.
module uart_sha_host #(
   parameter int unsigned RESP_TIMEOUT = 1_000_000,
   parameter int unsigned HASH_TIMEOUT = 0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [511:0] job_data,
   input  logic [255:0] job_state,
   input  logic [255:0] job_target,
   input  logic [31:0]  job_nonce_base,
   input  logic [31:0]  job_position,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic         result_valid,
   output logic [31:0]  result_nonce,
   output logic         err_valid,
   output logic [1:0]   err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_HS,
      S_WAIT_ACK,
      S_SEND_JOB,
      S_WAIT_START,
      S_WAIT_DONE,
      S_RECV_NONCE,
      S_ERR
   } state_t;

   localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
   localparam logic [31:0] HASH_LAST = 32'(HASH_TIMEOUT - 1);
   localparam logic [7:0]  LAST_IDX  = 8'd135;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_live;
   logic [1087:0]  r_shadow;
   logic [7:0]     r_idx;
   logic [1:0]     r_k;
   logic [31:0]    r_timer;
   logic [31:0]    r_nonce;
   logic [31:0]    r_result;
   logic [1:0]     r_err_code;
   logic [1:0]     w_err_code_nxt;
   logic           w_tx_fire;
   logic           w_rx_fire;
   logic           w_job_fire;
   logic           w_resp_tmo;
   logic           w_hash_tmo;
   logic           w_nonce_done;
   logic           w_waiting;
   logic [31:0]    w_nonce_full;

   assign w_tx_fire    = tx_valid && tx_ready;
   assign w_rx_fire    = rx_valid && rx_ready;
   assign w_job_fire   = job_valid && job_ready;
   assign w_resp_tmo   = (RESP_TIMEOUT != 0) && (r_timer == RESP_LAST);
   assign w_hash_tmo   = (HASH_TIMEOUT != 0) && (r_timer == HASH_LAST);
   assign w_nonce_done = (r_state == S_RECV_NONCE) && w_rx_fire && (r_k == 2'd3);
   assign w_nonce_full = {rx_data, r_nonce[31:8]};
   assign w_waiting    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_START) ||
                         (r_state == S_WAIT_DONE);

   assign err_valid    = (r_state == S_ERR);
   assign err_code     = r_err_code;
   assign result_valid = w_nonce_done;
   // The final nonce byte is forwarded combinationally so the result and its pulse coincide.
   assign result_nonce = w_nonce_done ? w_nonce_full : r_result;

   always_comb begin
      w_state_nxt    = r_state;
      w_err_code_nxt = r_err_code;
      job_ready      = 1'b0;
      rx_ready       = 1'b0;
      tx_valid       = 1'b0;
      tx_data        = '0;
      case (r_state)
         S_IDLE: begin
            job_ready = r_live;
            rx_ready  = r_live;
            if (w_job_fire) w_state_nxt = S_SEND_HS;
         end
         S_SEND_HS: begin
            tx_valid = 1'b1;
            tx_data  = 8'h48;
            if (tx_ready) w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'h31) begin
                  w_state_nxt = S_SEND_JOB;
               end else begin
                  w_state_nxt    = S_ERR;
                  w_err_code_nxt = 2'd1;
               end
            end else if (w_resp_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 2'd2;
            end
         end
         S_SEND_JOB: begin
            tx_valid = 1'b1;
            tx_data  = r_shadow[7:0];
            if (tx_ready && (r_idx == LAST_IDX)) w_state_nxt = S_WAIT_START;
         end
         S_WAIT_START: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'h53) begin
                  w_state_nxt = S_WAIT_DONE;
               end else begin
                  w_state_nxt    = S_ERR;
                  w_err_code_nxt = 2'd1;
               end
            end else if (w_resp_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 2'd2;
            end
         end
         S_WAIT_DONE: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == 8'h59) begin
                  w_state_nxt = S_RECV_NONCE;
               end else begin
                  w_state_nxt    = S_ERR;
                  w_err_code_nxt = 2'd1;
               end
            end else if (w_hash_tmo) begin
               w_state_nxt    = S_ERR;
               w_err_code_nxt = 2'd3;
            end
         end
         S_RECV_NONCE: begin
            rx_ready = 1'b1;
            if (w_nonce_done) w_state_nxt = S_IDLE;
         end
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_live     <= 1'b0;
         r_shadow   <= '0;
         r_idx      <= '0;
         r_k        <= '0;
         r_timer    <= '0;
         r_nonce    <= '0;
         r_result   <= '0;
         r_err_code <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_live     <= 1'b1;
         r_err_code <= w_err_code_nxt;

         if (!w_waiting || (w_state_nxt != r_state)) r_timer <= '0;
         else                                        r_timer <= r_timer + 32'd1;

         // Shadow is shifted out LSB byte first, so byte 0 of job_data leaves first.
         if (w_job_fire)
            r_shadow <= {job_position, job_nonce_base, job_target, job_state, job_data};
         else if ((r_state == S_SEND_JOB) && w_tx_fire)
            r_shadow <= {8'h00, r_shadow[1087:8]};

         if (w_job_fire)
            r_idx <= '0;
         else if ((r_state == S_SEND_JOB) && w_tx_fire && (r_idx != LAST_IDX))
            r_idx <= r_idx + 8'd1;

         if (r_state == S_WAIT_DONE)
            r_k <= '0;
         else if ((r_state == S_RECV_NONCE) && w_rx_fire)
            r_k <= r_k + 2'd1;

         if ((r_state == S_RECV_NONCE) && w_rx_fire) r_nonce <= w_nonce_full;
         if (w_nonce_done)                             r_result <= w_nonce_full;
      end
   end

endmodule

// File: tb/tb_uart_sha_host.sv
// Self-checking bench for uart_sha_host: a table of job scenarios plus hand
// sequences for timeouts and mid-job reset, checked against a byte-stream model.
module tb_uart_sha_host;

   logic         clk = 1'b0;
   logic         rstn;
   logic [511:0] job_data;
   logic [255:0] job_state;
   logic [255:0] job_target;
   logic [31:0]  job_nonce_base;
   logic [31:0]  job_position;
   logic         jv0, jv1;
   logic         tx_ready;
   logic [7:0]   rx_data;
   logic         rx_valid;

   logic         jr0, jr1, txv0, txv1, rxr0, rxr1, rv0, rv1, ev0, ev1;
   logic [7:0]   txd0, txd1;
   logic [31:0]  rn0, rn1;
   logic [1:0]   ec0, ec1;

   bit           sel;
   logic         w_job_ready, w_tx_valid, w_rx_ready, w_result_valid, w_err_valid;
   logic [7:0]   w_tx_data;
   logic [31:0]  w_result_nonce;
   logic [1:0]   w_err_code;

   always #5 clk = ~clk;

   uart_sha_host #(.RESP_TIMEOUT(100), .HASH_TIMEOUT(50)) u_dut0 (
      .clk(clk), .rstn(rstn), .job_valid(jv0), .job_ready(jr0),
      .job_data(job_data), .job_state(job_state), .job_target(job_target),
      .job_nonce_base(job_nonce_base), .job_position(job_position),
      .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr0),
      .result_valid(rv0), .result_nonce(rn0), .err_valid(ev0), .err_code(ec0)
   );

   uart_sha_host #(.RESP_TIMEOUT(100), .HASH_TIMEOUT(0)) u_dut1 (
      .clk(clk), .rstn(rstn), .job_valid(jv1), .job_ready(jr1),
      .job_data(job_data), .job_state(job_state), .job_target(job_target),
      .job_nonce_base(job_nonce_base), .job_position(job_position),
      .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr1),
      .result_valid(rv1), .result_nonce(rn1), .err_valid(ev1), .err_code(ec1)
   );

   assign w_job_ready    = sel ? jr1 : jr0;
   assign w_tx_valid     = sel ? txv1 : txv0;
   assign w_tx_data      = sel ? txd1 : txd0;
   assign w_rx_ready     = sel ? rxr1 : rxr0;
   assign w_result_valid = sel ? rv1 : rv0;
   assign w_result_nonce = sel ? rn1 : rn0;
   assign w_err_valid    = sel ? ev1 : ev0;
   assign w_err_code     = sel ? ec1 : ec0;

   typedef struct {
      bit         incr;
      bit         bp;
      logic [7:0] ack;
      logic [7:0] start;
      logic [7:0] done;
      logic [31:0] nonce;
      logic [1:0] exp_err;
   } vec_t;

   vec_t        vecs[7];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [7:0]  tx_log[$];
   logic [7:0]  exp_q[$];
   int          tx_edge, rx_edge, err_edge;
   int          res_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] res_val;
   logic [1:0]  err_seen;
   bit          bp = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         tx_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Observer of the selected DUT, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("tx_hold_valid", 32'(w_tx_valid), 32'd1);
               chk("tx_hold_data", 32'(w_tx_data), 32'(prev_data));
            end
            if (w_tx_valid && tx_ready) begin
               tx_log.push_back(w_tx_data);
               tx_edge = cyc + 1;
            end
            prev_stall = w_tx_valid && !tx_ready;
            prev_data  = w_tx_data;
            if (rx_valid && w_rx_ready) rx_edge = cyc + 1;
            if (w_result_valid) begin
               res_cnt++;
               res_val = w_result_nonce;
            end
            if (w_err_valid) begin
               err_cnt++;
               err_seen = w_err_code;
               err_edge = cyc;
            end
         end
      end
   end

   task automatic set_jv(input logic v);
      if (sel) jv1 = v;
      else     jv0 = v;
   endtask

   task automatic build_exp();
      exp_q.delete();
      exp_q.push_back(8'h48);
      for (int i = 0; i < 64; i++) exp_q.push_back(job_data[8*i +: 8]);
      for (int i = 0; i < 32; i++) exp_q.push_back(job_state[8*i +: 8]);
      for (int i = 0; i < 32; i++) exp_q.push_back(job_target[8*i +: 8]);
      for (int i = 0; i < 4; i++)  exp_q.push_back(job_nonce_base[8*i +: 8]);
      for (int i = 0; i < 4; i++)  exp_q.push_back(job_position[8*i +: 8]);
   endtask

   task automatic scramble();
      for (int i = 0; i < 16; i++) job_data[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) begin
         job_state[32*i +: 32]  = $urandom;
         job_target[32*i +: 32] = $urandom;
      end
      job_nonce_base = $urandom;
      job_position   = $urandom;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int t = 0;
      while (tx_log.size() < n && t < budget) begin
         @(posedge clk); #1;
         t++;
      end
      if (tx_log.size() < n) begin
         n_vec++;
         n_err++;
         $display("FAIL tx_wait: got %0d bytes, expected %0d", tx_log.size(), n);
      end
   endtask

   task automatic wait_err(input logic [1:0] code, input int budget);
      int t = 0;
      while (err_cnt == 0 && t < budget) begin
         @(posedge clk); #1;
         t++;
      end
      if (err_cnt == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL err_wait: got no err_valid, expected code %0d", code);
      end else begin
         chk("err_code", 32'(err_seen), 32'(code));
         @(posedge clk); #1;
         chk("err_pulse_count", err_cnt, 1);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      int t = 0;
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!w_rx_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!w_rx_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL rx_accept: got rx_ready 0, expected 1 for byte %h", b);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic offer_job(input bit incr, input bit s, input bit poke);
      sel = s;
      tx_log.delete();
      res_cnt = 0;
      err_cnt = 0;
      if (incr) begin
         for (int i = 0; i < 64; i++) job_data[8*i +: 8] = 8'(i);
         for (int i = 0; i < 32; i++) job_state[8*i +: 8] = 8'(64 + i);
         for (int i = 0; i < 32; i++) job_target[8*i +: 8] = 8'(96 + i);
         job_nonce_base = 32'h8382_8180;
         job_position   = 32'h8786_8584;
      end else begin
         scramble();
      end
      build_exp();
      @(posedge clk); #1;
      set_jv(1'b1);
      @(negedge clk);
      chk("job_ready_idle", 32'(w_job_ready), 32'd1);
      @(posedge clk); #1;
      scramble();
      if (!poke) set_jv(1'b0);
      @(negedge clk);
      chk("h_latency_valid", 32'(w_tx_valid), 32'd1);
      chk("h_latency_data", 32'(w_tx_data), 32'h48);
      chk("job_ready_busy", 32'(w_job_ready), 32'd0);
   endtask

   task automatic run_job(input vec_t v, input bit s, input int dly_y);
      bp = v.bp;
      offer_job(v.incr, s, 1'b1);
      wait_tx(1, 100);
      chk("h_byte", 32'(tx_log[0]), 32'h48);
      if (v.ack != 8'h31) begin
         set_jv(1'b0);
         send_rx(v.ack);
         wait_err(v.exp_err, 300);
         repeat (5) @(negedge clk);
         chk("no_job_bytes", tx_log.size(), 1);
      end else begin
         send_rx(8'h31);
         wait_tx(137, 3000);
         set_jv(1'b0);
         chk("stream_len", tx_log.size(), 137);
         if (tx_log.size() == 137)
            for (int i = 0; i < 137; i++) chk("stream_byte", 32'(tx_log[i]), 32'(exp_q[i]));
         bp = 1'b0;
         send_rx(v.start);
         if (v.start != 8'h53) begin
            wait_err(v.exp_err, 300);
         end else begin
            repeat (dly_y) @(posedge clk);
            if (dly_y > 0) chk("no_err_while_hashing", err_cnt, 0);
            send_rx(v.done);
            if (v.done != 8'h59) begin
               wait_err(v.exp_err, 300);
            end else begin
               for (int k = 0; k < 4; k++) send_rx(v.nonce[8*k +: 8]);
               chk("result_pulses", res_cnt, 1);
               chk("result_nonce", res_val, v.nonce);
               chk("no_err_on_success", err_cnt, 0);
               @(negedge clk);
               chk("result_nonce_held", w_result_nonce, v.nonce);
            end
         end
      end
      bp = 1'b0;
      @(negedge clk);
      chk("job_ready_back", 32'(w_job_ready), 32'd1);
      chk("tx_valid_idle", 32'(w_tx_valid), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_job_ready", 32'(w_job_ready), 32'd0);
      chk("rst_tx_valid", 32'(w_tx_valid), 32'd0);
      chk("rst_tx_data", 32'(w_tx_data), 32'd0);
      chk("rst_rx_ready", 32'(w_rx_ready), 32'd0);
      chk("rst_result_valid", 32'(w_result_valid), 32'd0);
      chk("rst_result_nonce", w_result_nonce, 32'd0);
      chk("rst_err_valid", 32'(w_err_valid), 32'd0);
      chk("rst_err_code", 32'(w_err_code), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{incr: 1, bp: 0, ack: 8'h31, start: 8'h53, done: 8'h59, nonce: 32'hDEAD_BEEF, exp_err: 2'd0};
      vecs[1] = '{incr: 1, bp: 0, ack: 8'h45, start: 8'h53, done: 8'h59, nonce: 32'h0,         exp_err: 2'd1};
      vecs[2] = '{incr: 1, bp: 1, ack: 8'h31, start: 8'h53, done: 8'h59, nonce: 32'hDEAD_BEEF, exp_err: 2'd0};
      vecs[3] = '{incr: 0, bp: 1, ack: 8'h31, start: 8'h53, done: 8'h59, nonce: 32'h1234_5678, exp_err: 2'd0};
      vecs[4] = '{incr: 0, bp: 0, ack: 8'h31, start: 8'h51, done: 8'h59, nonce: 32'h0,         exp_err: 2'd1};
      vecs[5] = '{incr: 0, bp: 1, ack: 8'h31, start: 8'h53, done: 8'h5A, nonce: 32'h0,         exp_err: 2'd1};
      vecs[6] = '{incr: 0, bp: 0, ack: 8'h31, start: 8'h53, done: 8'h59, nonce: 32'hA5A5_0001, exp_err: 2'd0};

      rstn = 1'b0;
      jv0 = 1'b0;
      jv1 = 1'b0;
      rx_valid = 1'b0;
      rx_data = '0;
      job_data = '0;
      job_state = '0;
      job_target = '0;
      job_nonce_base = '0;
      job_position = '0;
      repeat (3) @(negedge clk);
      sel = 1'b0; #1;
      chk_reset_outputs();
      sel = 1'b1; #1;
      chk_reset_outputs();
      sel = 1'b0;

      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_job_ready", 32'(w_job_ready), 32'd1);
      chk("idle_rx_ready", 32'(w_rx_ready), 32'd1);
      send_rx(8'h53);
      repeat (3) @(negedge clk);
      chk("idle_rx_dropped_no_err", err_cnt, 0);
      chk("idle_rx_dropped_ready", 32'(w_job_ready), 32'd1);

      foreach (vecs[i]) run_job(vecs[i], 1'b0, 0);

      // Silent miner after 'H'
      bp = 1'b0;
      offer_job(1'b1, 1'b0, 1'b0);
      wait_tx(1, 100);
      wait_err(2'd2, 300);
      chk("resp_tmo_delay", err_edge - tx_edge, 100);
      chk("resp_tmo_no_job_bytes", tx_log.size(), 1);

      // 'S' but no 'Y'
      offer_job(1'b0, 1'b0, 1'b0);
      wait_tx(1, 100);
      send_rx(8'h31);
      wait_tx(137, 1000);
      send_rx(8'h53);
      wait_err(2'd3, 300);
      chk("hash_tmo_delay", err_edge - rx_edge, 50);

      // Hash timeout disabled: a very late 'Y' still succeeds
      run_job(vecs[0], 1'b1, 10000);
      sel = 1'b0;

      // Reset while idx = 70
      bp = 1'b0;
      offer_job(1'b1, 1'b0, 1'b0);
      wait_tx(1, 100);
      send_rx(8'h31);
      wait_tx(71, 500);
      rstn = 1'b0;
      #1;
      chk_reset_outputs();
      @(posedge clk); #1;
      rstn = 1'b1;
      run_job(vecs[0], 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
